// File: rtl/sensor_capture_if.sv
`default_nettype none
// ============================================================================
//  Module   : sensor_capture_if
//  Brief    : Bundles the sensor-side inputs, the operator start/stop requests
//             and the captured pixel stream of sensor_capture.
//  Revision : 1.0 - initial release
// ============================================================================
interface sensor_capture_if;
  // Sensor side and operator requests
  logic [11:0] sensor_data;
  logic        sensor_fval;
  logic        sensor_lval;
  logic        start;
  logic        stop;
  // Captured pixel stream towards the demosaic stage
  logic [11:0] pix_data;
  logic        pix_dval;
  logic [15:0] x_cont;
  logic [15:0] y_cont;
  logic [31:0] frame_cont;
  logic        capturing;

  // Source of sensor stream and requests, sink of the captured stream
  modport master (
    output sensor_data, sensor_fval, sensor_lval, start, stop,
    input  pix_data, pix_dval, x_cont, y_cont, frame_cont, capturing
  );

  // The capture block itself
  modport slave (
    input  sensor_data, sensor_fval, sensor_lval, start, stop,
    output pix_data, pix_dval, x_cont, y_cont, frame_cont, capturing
  );
endinterface
`default_nettype wire

// File: rtl/sensor_capture.sv
`default_nettype none
// ============================================================================
//  Module   : sensor_capture
//  Brief    : Registers the 12-bit Bayer sensor stream, gates whole frames on
//             start/stop requests and tags each captured pixel with X/Y.
//  Revision : 1.0 - initial release
// ============================================================================
module sensor_capture #(
  parameter int COLUMN_WIDTH = 1280
) (
  input  logic           clk,
  input  logic           rst,
  sensor_capture_if.slave bus
);

  localparam logic [15:0] C_LAST_COL = 16'(COLUMN_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARMED  = 2'd1,
    S_ACTIVE = 2'd2
  } state_t;

  // Stage 1 and edge-detect history
  logic [11:0] r_data;
  logic        r_fval;
  logic        r_lval;
  logic        p_fval;
  logic        p_lval;

  // Control and datapath state
  state_t      state;
  logic        stop_pending;
  logic [15:0] xc;
  logic [15:0] yc;
  logic [11:0] out_data;
  logic        out_dval;
  logic [15:0] out_x;
  logic [15:0] out_y;
  logic [31:0] frame_cnt;

  logic        fval_rise;
  logic        fval_fall;
  logic        lval_fall;
  logic        pix_v;

  assign fval_rise = r_fval & ~p_fval;
  assign fval_fall = ~r_fval & p_fval;
  assign lval_fall = ~r_lval & p_lval;
  // Uses the registered state, so the sensor must leave a gap between the
  // frame-valid rise and the first line-valid rise.
  assign pix_v     = r_lval & r_fval & (state == S_ACTIVE);

  // Register the raw sensor signals and keep one more cycle for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
      r_fval <= 1'b0;
      r_lval <= 1'b0;
      p_fval <= 1'b0;
      p_lval <= 1'b0;
    end else begin
      r_data <= bus.sensor_data;
      r_fval <= bus.sensor_fval;
      r_lval <= bus.sensor_lval;
      p_fval <= r_fval;
      p_lval <= r_lval;
    end
  end

  // Frame-gating FSM with coordinate counters and registered pixel outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      stop_pending <= 1'b0;
      xc           <= '0;
      yc           <= '0;
      out_data     <= '0;
      out_dval     <= 1'b0;
      out_x        <= '0;
      out_y        <= '0;
      frame_cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start && !bus.stop) state <= S_ARMED;
        end
        S_ARMED: begin
          // Stop wins over a coincident frame start; a frame already running
          // when armed is skipped because only a fresh rise enters ACTIVE.
          if (bus.stop) begin
            state <= S_IDLE;
          end else if (fval_rise) begin
            state     <= S_ACTIVE;
            frame_cnt <= frame_cnt + 32'd1;
            xc        <= '0;
            yc        <= '0;
          end
        end
        S_ACTIVE: begin
          if (fval_fall) begin
            if (stop_pending || bus.stop) begin
              state        <= S_IDLE;
              stop_pending <= 1'b0;
            end else begin
              state <= S_ARMED;
            end
          end else if (bus.stop) begin
            stop_pending <= 1'b1;
          end
        end
        default: begin
          state        <= S_IDLE;
          stop_pending <= 1'b0;
        end
      endcase

      if (pix_v) begin
        out_data <= r_data;
        out_dval <= 1'b1;
        out_x    <= xc;
        out_y    <= yc;
        if (xc == C_LAST_COL) begin
          xc <= '0;
          yc <= yc + 16'd1;
        end else begin
          xc <= xc + 16'd1;
        end
      end else begin
        out_dval <= 1'b0;
        // A line that ended before filling the row still advances the row
        if (lval_fall && (state == S_ACTIVE) && (xc != 16'd0)) begin
          xc <= '0;
          yc <= yc + 16'd1;
        end
      end
    end
  end

  assign bus.pix_data   = out_data;
  assign bus.pix_dval   = out_dval;
  assign bus.x_cont     = out_x;
  assign bus.y_cont     = out_y;
  assign bus.frame_cont = frame_cnt;
  assign bus.capturing  = (state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sensor_capture.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sensor_capture
//  Brief    : Scoreboard bench for sensor_capture with COLUMN_WIDTH=4.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sensor_capture;

  localparam int COLS = 4;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   failures;

  typedef struct {
    logic [11:0] data;
    int          x;
    int          y;
    int          when;
  } exp_t;

  exp_t sb[$];

  sensor_capture_if bus ();

  sensor_capture #(.COLUMN_WIDTH(COLS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pop and compare every pixel the DUT emits
  always @(negedge clk) begin
    if (bus.pix_dval === 1'b1) begin
      if (sb.size() == 0) begin
        check_val("spurious_dval", 32'(bus.pix_dval), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_val("pix_data", 32'(bus.pix_data), 32'(e.data));
        check_val("pix_x", 32'(bus.x_cont), 32'(e.x));
        check_val("pix_y", 32'(bus.y_cont), 32'(e.y));
        check_val("latency", 32'(cyc), 32'(e.when));
      end
    end
  end

  task automatic pulse_req(input bit s, input bit e);
    bus.start = s;
    bus.stop  = e;
    tick();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // One sensor frame; start_ln/stop_ln/rst_ln pick the line where the request
  // is raised (-1 for none); end_cap < 0 skips the end-of-frame check.
  task automatic drive_frame(input int nl, input int len0, input int len1,
                             input bit cap, input int exp_fc,
                             input int start_ln, input int stop_ln,
                             input int rst_ln, input int end_cap,
                             input logic [11:0] base);
    int          mx;
    int          my;
    int          len;
    bit          c;
    bit          did_rst;
    logic [11:0] d;
    mx = 0; my = 0; c = cap; d = base;
    bus.sensor_fval = 1'b1;
    tick();
    if (cap) check_val("fc_before_rise", bus.frame_cont, 32'(exp_fc - 1));
    tick();
    if (cap) check_val("fc_after_rise", bus.frame_cont, 32'(exp_fc));
    tick();
    for (int ln = 0; ln < nl; ln++) begin
      len = (ln == 0) ? len0 : len1;
      for (int p = 0; p < len; p++) begin
        did_rst         = (ln == rst_ln) && (p == 2);
        bus.sensor_lval = 1'b1;
        bus.sensor_data = d;
        bus.start       = (ln == start_ln) && (p == 1);
        bus.stop        = (ln == stop_ln) && (p == 1);
        rst             = did_rst;
        if (did_rst) begin
          for (int i = sb.size() - 1; i >= 0; i--)
            if (sb[i].when > cyc) sb.delete(i);
          c = 1'b0;
        end else if (c) begin
          sb.push_back('{data: d, x: mx, y: my, when: cyc + 2});
          if (mx == COLS - 1) begin
            mx = 0;
            my++;
          end else begin
            mx++;
          end
        end
        d = d + 12'd1;
        tick();
        rst = 1'b0;
        if (did_rst) begin
          check_val("rst_data", 32'(bus.pix_data), 32'd0);
          check_val("rst_dval", 32'(bus.pix_dval), 32'd0);
          check_val("rst_x", 32'(bus.x_cont), 32'd0);
          check_val("rst_y", 32'(bus.y_cont), 32'd0);
          check_val("rst_fc", bus.frame_cont, 32'd0);
          check_val("rst_cap", 32'(bus.capturing), 32'd0);
        end
      end
      bus.sensor_lval = 1'b0;
      bus.start       = 1'b0;
      bus.stop        = 1'b0;
      if (c && mx != 0) begin
        mx = 0;
        my++;
      end
      tick();
      tick();
    end
    bus.sensor_fval = 1'b0;
    tick();
    if (end_cap >= 0) check_val("cap_at_fall", 32'(bus.capturing), 32'd1);
    tick();
    if (end_cap >= 0) check_val("cap_after_fall", 32'(bus.capturing), 32'(end_cap));
    tick();
    tick();
  endtask

  initial begin
    cyc = 0; checks = 0; failures = 0;
    rst = 1'b1;
    bus.sensor_data = '0;
    bus.sensor_fval = 1'b0;
    bus.sensor_lval = 1'b0;
    bus.start       = 1'b0;
    bus.stop        = 1'b0;
    tick();
    tick();
    check_val("reset_data", 32'(bus.pix_data), 32'd0);
    check_val("reset_dval", 32'(bus.pix_dval), 32'd0);
    check_val("reset_x", 32'(bus.x_cont), 32'd0);
    check_val("reset_y", 32'(bus.y_cont), 32'd0);
    check_val("reset_fc", bus.frame_cont, 32'd0);
    check_val("reset_cap", 32'(bus.capturing), 32'd0);
    rst = 1'b0;
    tick();

    // Simultaneous start/stop in IDLE, then in ARMED
    pulse_req(1'b1, 1'b1);
    check_val("both_idle", 32'(bus.capturing), 32'd0);
    pulse_req(1'b1, 1'b0);
    check_val("armed", 32'(bus.capturing), 32'd1);
    pulse_req(1'b1, 1'b1);
    check_val("both_armed", 32'(bus.capturing), 32'd0);

    // Basic 2x4 frame, then stop while armed
    do_reset();
    pulse_req(1'b1, 1'b0);
    drive_frame(2, 4, 4, 1'b1, 1, -1, -1, -1, 1, 12'h100);
    check_val("basic_fc", bus.frame_cont, 32'd1);
    pulse_req(1'b0, 1'b1);
    check_val("basic_stop", 32'(bus.capturing), 32'd0);

    // Arm while a frame is running: that frame is skipped
    do_reset();
    drive_frame(1, 2, 2, 1'b0, 0, -1, -1, -1, -1, 12'h050);
    bus.sensor_fval = 1'b1;
    tick();
    tick();
    tick();
    drive_frame(3, 4, 4, 1'b0, 0, 1, -1, -1, -1, 12'h200);
    check_val("midarm_fc0", bus.frame_cont, 32'd0);
    drive_frame(2, 4, 4, 1'b1, 1, -1, -1, -1, 1, 12'h300);
    check_val("midarm_fc1", bus.frame_cont, 32'd1);
    pulse_req(1'b0, 1'b1);

    // Short then long line
    do_reset();
    pulse_req(1'b1, 1'b0);
    drive_frame(2, 3, 6, 1'b1, 1, -1, -1, -1, 1, 12'h400);
    pulse_req(1'b0, 1'b1);

    // Stop requested during frame 3 of continuous capture
    do_reset();
    pulse_req(1'b1, 1'b0);
    drive_frame(2, 4, 4, 1'b1, 1, -1, -1, -1, 1, 12'h500);
    drive_frame(2, 4, 4, 1'b1, 2, -1, -1, -1, 1, 12'h510);
    drive_frame(2, 4, 4, 1'b1, 3, -1, 1, -1, 0, 12'h520);
    drive_frame(2, 4, 4, 1'b0, 0, -1, -1, -1, -1, 12'h530);
    check_val("stop_fc", bus.frame_cont, 32'd3);

    // Reset at pixel (2,1), then no capture until a new start and frame
    do_reset();
    pulse_req(1'b1, 1'b0);
    drive_frame(2, 4, 4, 1'b1, 1, -1, -1, 1, -1, 12'h600);
    drive_frame(2, 4, 4, 1'b0, 0, -1, -1, -1, -1, 12'h610);
    check_val("post_rst_fc", bus.frame_cont, 32'd0);
    pulse_req(1'b1, 1'b0);
    drive_frame(2, 4, 4, 1'b1, 1, -1, -1, -1, 1, 12'h620);

    tick();
    tick();
    check_val("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
